// File: rtl/butterfly_pipe_if.sv
// butterfly_pipe_if: valid/ready handshake and complex operand/result bus of the butterfly
interface butterfly_pipe_if #(
  parameter int DW = 16,
  parameter int TW = 16
);
  logic in_valid, in_ready, inverse, out_valid, out_ready;
  logic signed [DW-1:0] a_re, a_im, b_re, b_im;
  logic signed [DW-1:0] x_re, x_im, y_re, y_im;
  logic signed [TW-1:0] tw_re, tw_im;
  modport master (
    output in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, inverse, out_ready,
    input  in_ready, out_valid, x_re, x_im, y_re, y_im
  );
  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, inverse, out_ready,
    output in_ready, out_valid, x_re, x_im, y_re, y_im
  );
endinterface

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 4-stage radix-2 DIT butterfly X=A+W*B, Y=A-W*B with rounding, optional halving and saturation
module butterfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter int SCALE = 0
) (
  input  logic clk,
  input  logic rst,
  butterfly_pipe_if.slave bus,
  input  logic ovf_clr,
  output logic ovf
);
  localparam int PW = DW + TW + 1;
  localparam int SW = DW + 2;
  localparam int WW = TW + 1;
  localparam logic signed [PW-1:0] RND = PW'(2 ** (TW - 2));
  localparam logic signed [SW-1:0] ONE = SW'(1);
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DW - 1) - 1);
  localparam logic signed [SW-1:0] MINV = -SW'(2 ** (DW - 1));
  logic v1, v2, v3, v4, adv, hit;
  logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im, a2_re, a2_im, a3_re, a3_im;
  logic signed [TW-1:0] w1_re;
  logic signed [WW-1:0] w1_im;
  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [SW-1:0] p_re, p_im, s_xr, s_xi, s_yr, s_yi;
  function automatic logic signed [SW-1:0] half(input logic signed [SW-1:0] v);
    return SCALE != 0 ? (v + ONE) >>> 1 : v;
  endfunction
  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    return v > MAXV ? MAXV[DW-1:0] : v < MINV ? MINV[DW-1:0] : v[DW-1:0];
  endfunction
  function automatic logic oor(input logic signed [SW-1:0] v);
    return v > MAXV || v < MINV;
  endfunction
  assign adv = bus.out_ready | ~v4;
  assign bus.in_ready = adv;
  assign bus.out_valid = v4;
  // final sums A +/- P, halved when scaling, plus the saturation detect for the sample in S3
  always_comb begin
    s_xr = half(SW'(a3_re) + p_re);
    s_xi = half(SW'(a3_im) + p_im);
    s_yr = half(SW'(a3_re) - p_re);
    s_yi = half(SW'(a3_im) - p_im);
    hit = v3 & (oor(s_xr) | oor(s_xi) | oor(s_yr) | oor(s_yi));
  end
  // stage valid bits and output registers; the whole pipe moves only when the output can advance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1, v2, v3, v4} <= '0;
      bus.x_re <= '0;
      bus.x_im <= '0;
      bus.y_re <= '0;
      bus.y_im <= '0;
    end else if (adv) begin
      {v1, v2, v3, v4} <= {bus.in_valid, v1, v2, v3};
      if (v3) begin
        bus.x_re <= sat(s_xr);
        bus.x_im <= sat(s_xi);
        bus.y_re <= sat(s_yr);
        bus.y_im <= sat(s_yi);
      end
    end
  // S1..S3 datapath, loaded only behind a valid sample so idle input data leaves no trace
  always_ff @(posedge clk)
    if (adv) begin
      if (bus.in_valid) begin
        a1_re <= bus.a_re;
        a1_im <= bus.a_im;
        b1_re <= bus.b_re;
        b1_im <= bus.b_im;
        w1_re <= bus.tw_re;
        w1_im <= bus.inverse ? -WW'(bus.tw_im) : WW'(bus.tw_im);
      end
      if (v1) begin
        a2_re <= a1_re;
        a2_im <= a1_im;
        m_rr <= PW'(b1_re) * PW'(w1_re);
        m_ii <= PW'(b1_im) * PW'(w1_im);
        m_ri <= PW'(b1_re) * PW'(w1_im);
        m_ir <= PW'(b1_im) * PW'(w1_re);
      end
      if (v2) begin
        a3_re <= a2_re;
        a3_im <= a2_im;
        p_re <= SW'((m_rr - m_ii + RND) >>> (TW - 1));
        p_im <= SW'((m_ri + m_ir + RND) >>> (TW - 1));
      end
    end
  // sticky overflow; a new saturation beats a simultaneous clear
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (adv & hit) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
endmodule
